// File: rtl/adler32_stream.sv
// Streaming Adler-32 engine. It consumes up to LANES bytes per beat for a message of known length
// and reports {B, A} with a one-cycle valid pulse when the message is complete.
module adler32_stream #(
    parameter int LANES  = 4,
    parameter int SIZE_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               size_valid,
    input  logic [SIZE_W-1:0]  size,
    input  logic               seed_en,
    input  logic [31:0]        seed,
    input  logic               data_valid,
    input  logic [8*LANES-1:0] data,
    output logic               busy,
    output logic               checksum_valid,
    output logic [31:0]        checksum
);

    localparam logic [16:0]       MOD     = 17'd65521;
    localparam logic [SIZE_W-1:0] LANES_W = SIZE_W'(LANES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [15:0]       r_a;
    logic [15:0]       r_b;
    logic [SIZE_W-1:0] r_rem;
    logic              r_valid;

    logic              w_load;
    logic              w_beat;
    logic              w_fire;
    logic [16:0]       w_a_sum;
    logic [16:0]       w_b_sum;
    logic [SIZE_W-1:0] w_take;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_beat = 1'b0;
        w_fire = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (size_valid) begin
                    w_load = 1'b1;
                    if (size == '0) begin
                        w_next = DONE;
                        w_fire = 1'b1;
                    end else begin
                        w_next = RUN;
                    end
                end
            end
            RUN: begin
                if (data_valid) begin
                    w_beat = 1'b1;
                    if (r_rem <= LANES_W) begin
                        w_next = DONE;
                        w_fire = 1'b1;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Seed halves may arrive unreduced, so they are folded once before the byte chain.
    // Each byte step keeps both sums below 2*MOD, which makes one conditional subtract enough.
    always_comb begin
        w_a_sum = {1'b0, r_a};
        w_b_sum = {1'b0, r_b};
        if (w_a_sum >= MOD) w_a_sum = w_a_sum - MOD;
        if (w_b_sum >= MOD) w_b_sum = w_b_sum - MOD;
        for (int k = 0; k < LANES; k++) begin
            if (r_rem > SIZE_W'(k)) begin
                w_a_sum = w_a_sum + {9'd0, data[8*k +: 8]};
                if (w_a_sum >= MOD) w_a_sum = w_a_sum - MOD;
                w_b_sum = w_b_sum + w_a_sum;
                if (w_b_sum >= MOD) w_b_sum = w_b_sum - MOD;
            end
        end
    end

    assign w_take = (r_rem < LANES_W) ? r_rem : LANES_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= 16'h0001;
            r_b     <= 16'h0000;
            r_rem   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_fire;
            if (w_load) begin
                r_a   <= seed_en ? seed[15:0]  : 16'h0001;
                r_b   <= seed_en ? seed[31:16] : 16'h0000;
                r_rem <= size;
            end else if (w_beat) begin
                r_a   <= w_a_sum[15:0];
                r_b   <= w_b_sum[15:0];
                r_rem <= r_rem - w_take;
            end
        end
    end

    assign busy           = (r_state == RUN);
    assign checksum_valid = r_valid;
    assign checksum       = {r_b, r_a};

endmodule
